nttn_result_serializer: RTL and testbench

- Sits directly downstream of the NTTN core.
- When NTTN pulses done, it streams its result as one wide row of 2*PE_NUMBER coefficients per cycle on bramOut, with no backpressure. This block captures all RING_SIZE/(2*PE_NUMBER) rows into a local row buffer.
- It then drains them one coefficient per beat on a valid/ready stream, in natural index order, to the host/DMA side.
- Capture is lossless; drain is fully back-pressurable.

---
 rtl/nttn_result_serializer_pkg.sv | 25 ++
 rtl/nttn_row_buffer.sv | 40 ++++
 rtl/nttn_result_serializer.sv | 192 +++++++++++++++++++
 tb/tb_nttn_result_serializer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nttn_result_serializer_pkg.sv
// +----------------------------------------------------------------------------+
// | nttn_result_serializer_pkg                                                 |
// | Shared sizing constants and FSM encoding for the NTTN result serializer.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package nttn_result_serializer_pkg;

  localparam int NTTN_DATA_SIZE  = 64;
  localparam int NTTN_RING_DEPTH = 10;
  localparam int NTTN_PE_DEPTH   = 3;
  localparam int NTTN_PE_NUMBER  = 1 << NTTN_PE_DEPTH;
  localparam int NTTN_RING_SIZE  = 1 << NTTN_RING_DEPTH;
  localparam int NTTN_ROWS       = NTTN_RING_SIZE >> (NTTN_PE_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/nttn_row_buffer.sv
// +----------------------------------------------------------------------------+
// | nttn_row_buffer                                                            |
// | Simple dual-port row RAM: one write port, one registered read port.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module nttn_row_buffer #(
  parameter int WIDTH = 1024,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/nttn_result_serializer.sv
// +----------------------------------------------------------------------------+
// | nttn_result_serializer                                                     |
// | Captures an NTTN result frame row-wise, drains it one coefficient a beat.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module nttn_result_serializer
  import nttn_result_serializer_pkg::*;
#(
  parameter int DATA_SIZE  = NTTN_DATA_SIZE,
  parameter int RING_DEPTH = NTTN_RING_DEPTH,
  parameter int PE_DEPTH   = NTTN_PE_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   done,
  input  logic                                   op_intt,
  input  logic [DATA_SIZE*2*(1<<PE_DEPTH)-1:0]   bramOut,
  output logic [DATA_SIZE-1:0]                   dout,
  output logic                                   dout_valid,
  input  logic                                   dout_ready,
  output logic [RING_DEPTH-1:0]                  dout_idx,
  output logic                                   dout_last,
  output logic                                   dout_intt,
  output logic                                   busy,
  output logic                                   overrun
);

  localparam int PE_NUMBER = 1 << PE_DEPTH;
  localparam int LANES     = 2 * PE_NUMBER;
  localparam int LANE_W    = PE_DEPTH + 1;
  localparam int RING_SIZE = 1 << RING_DEPTH;
  localparam int ROWS      = RING_SIZE >> LANE_W;
  localparam int ROW_W     = RING_DEPTH - LANE_W;

  state_t                           r_state, w_state_next;
  logic [ROW_W-1:0]                 r_row_cnt;
  logic [RING_DEPTH-1:0]            r_issue_k, r_out_k;
  logic                             r_issue_all, r_rd_vld;
  logic [LANE_W-1:0]                r_rd_lane;
  logic [1:0]                       r_skid_cnt;
  logic [DATA_SIZE-1:0]             r_skid0, r_skid1;
  logic                             r_intt, r_overrun;
  logic                             w_pop, w_final_hs, w_accept, w_issue, w_wr_en, w_room;
  logic [1:0]                       w_occ;
  logic [LANES*DATA_SIZE-1:0]       w_rd_row;
  logic [LANES-1:0][DATA_SIZE-1:0]  w_rd_lanes;
  logic [DATA_SIZE-1:0]             w_lane_word;

  nttn_row_buffer #(
    .WIDTH (LANES * DATA_SIZE),
    .DEPTH (ROWS)
  ) u_row_buffer (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_row_cnt),
    .wr_data (bramOut),
    .rd_en   (w_issue),
    .rd_addr (r_issue_k[RING_DEPTH-1:LANE_W]),
    .rd_data (w_rd_row)
  );

  assign w_rd_lanes  = w_rd_row;
  assign w_lane_word = w_rd_lanes[r_rd_lane];

  // A read issued now lands in the skid two edges later; only issue if it is
  // guaranteed a free slot even when the consumer stalls meanwhile.
  always_comb begin
    w_pop      = (r_skid_cnt != 2'd0) && dout_ready;
    w_final_hs = (r_state == ST_DRAIN) && w_pop && (&r_out_k);
    w_occ      = r_skid_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
    w_room     = (w_occ <= 2'd1);
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_wr_en      = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (done) begin
          w_accept     = 1'b1;
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_wr_en = 1'b1;
        // Prefetch row 0 alongside the last row write to hit the drain latency.
        w_issue = (&r_row_cnt) && w_room;
        if (&r_row_cnt) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_issue = !r_issue_all && w_room;
        if (w_final_hs) begin
          if (done) begin
            w_accept     = 1'b1;
            w_state_next = ST_CAPTURE;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_row_cnt   <= '0;
      r_issue_k   <= '0;
      r_issue_all <= 1'b0;
      r_out_k     <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_lane   <= '0;
      r_skid_cnt  <= 2'd0;
      r_skid0     <= '0;
      r_skid1     <= '0;
      r_intt      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (done && !w_accept) begin
        r_overrun <= 1'b1;
      end
      if (w_accept) begin
        r_intt      <= op_intt;
        r_row_cnt   <= '0;
        r_issue_k   <= '0;
        r_issue_all <= 1'b0;
        r_out_k     <= '0;
      end else begin
        if (w_wr_en) begin
          r_row_cnt <= r_row_cnt + ROW_W'(1);
        end
        if (w_issue) begin
          r_issue_k <= r_issue_k + RING_DEPTH'(1);
          if (&r_issue_k) begin
            r_issue_all <= 1'b1;
          end
        end
        if (w_pop) begin
          r_out_k <= r_out_k + RING_DEPTH'(1);
        end
      end

      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_lane <= r_issue_k[LANE_W-1:0];
      end

      case ({r_rd_vld, w_pop})
        2'b10: begin
          if (r_skid_cnt == 2'd0) begin
            r_skid0 <= w_lane_word;
          end else begin
            r_skid1 <= w_lane_word;
          end
          r_skid_cnt <= r_skid_cnt + 2'd1;
        end
        2'b01: begin
          r_skid0    <= r_skid1;
          r_skid_cnt <= r_skid_cnt - 2'd1;
        end
        2'b11: begin
          if (r_skid_cnt == 2'd1) begin
            r_skid0 <= w_lane_word;
          end else begin
            r_skid0 <= r_skid1;
            r_skid1 <= w_lane_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout       = r_skid0;
  assign dout_valid = (r_skid_cnt != 2'd0);
  assign dout_idx   = r_out_k;
  assign dout_last  = dout_valid && (&r_out_k);
  assign dout_intt  = r_intt;
  assign busy       = (r_state != ST_IDLE) || dout_valid;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_nttn_result_serializer.sv
// +----------------------------------------------------------------------------+
// | tb_nttn_result_serializer                                                  |
// | Directed frame sequence with random data, checked against a row model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_nttn_result_serializer;
  import nttn_result_serializer_pkg::*;

  localparam int DW    = NTTN_DATA_SIZE;
  localparam int LANES = 2 * NTTN_PE_NUMBER;
  localparam int ROWS  = NTTN_ROWS;
  localparam int RSZ   = NTTN_RING_SIZE;
  localparam int LAT   = ROWS + 2;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic                        done = 1'b0;
  logic                        op_intt = 1'b0;
  logic                        dout_ready = 1'b0;
  logic [DW*LANES-1:0]         bramOut = '0;
  logic [DW-1:0]               dout;
  logic                        dout_valid, dout_last, dout_intt, busy, overrun;
  logic [NTTN_RING_DEPTH-1:0]  dout_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc = 0;
  logic [DW-1:0] rows [ROWS][LANES];
  logic [15:0]   lfsr;

  always #5 clk = ~clk;

  nttn_result_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .done       (done),
    .op_intt    (op_intt),
    .bramOut    (bramOut),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_idx   (dout_idx),
    .dout_last  (dout_last),
    .dout_intt  (dout_intt),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rows(input bit rnd, input logic [DW-1:0] base);
    for (int r = 0; r < ROWS; r++) begin
      for (int n = 0; n < LANES; n++) begin
        rows[r][n] = rnd ? {$urandom, $urandom} : base + DW'(LANES * r + n);
      end
    end
  endtask

  task automatic start_frame(input logic intt);
    done     = 1'b1;
    op_intt  = intt;
    done_cyc = cyc;
    tick();
    done     = 1'b0;
    op_intt  = 1'($urandom);
  endtask

  // Current cycle is the one after done: present rows, optionally a stray done.
  task automatic drive_rows(input int extra_at);
    for (int r = 0; r < ROWS; r++) begin
      for (int n = 0; n < LANES; n++) begin
        bramOut[n*DW +: DW] = rows[r][n];
      end
      done = (r + 1 == extra_at);
      if (r == 10) begin
        chk("busy_in_capture", busy, 1);
        chk("no_valid_in_capture", dout_valid, 0);
      end
      if (extra_at > 0 && r + 1 == extra_at)     chk("overrun_before", overrun, 0);
      if (extra_at > 0 && r + 1 == extra_at + 1) chk("overrun_set", overrun, 1);
      tick();
    end
    done = 1'b0;
    for (int n = 0; n < LANES; n++) begin
      bramOut[n*DW +: DW] = {$urandom, $urandom};
    end
  endtask

  task automatic drain(input bit bp, input bit b2b, input int abort_at, input logic exp_intt);
    int k = 0;
    int budget = 0;
    bit seen = 1'b0;
    bit stalled = 1'b0;
    logic [DW-1:0] h_dout;
    logic [NTTN_RING_DEPTH-1:0] h_idx;
    logic h_last, h_intt;
    h_dout = '0;
    h_idx  = '0;
    h_last = 1'b0;
    h_intt = 1'b0;
    chk("valid_before_latency", dout_valid, 0);
    while (k < RSZ) begin
      if (budget > 20000) begin
        chk("drain_timeout_beats", k, RSZ);
        break;
      end
      budget++;
      dout_ready = bp ? lfsr[0] : 1'b1;
      if (bp) lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (dout_valid && !seen) begin
        seen = 1'b1;
        chk("first_valid_latency", cyc - done_cyc, LAT);
      end
      if (stalled) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_dout", dout, h_dout);
        chk("hold_idx", dout_idx, h_idx);
        chk("hold_last", dout_last, h_last);
        chk("hold_intt", dout_intt, h_intt);
      end
      if (abort_at == k && dout_valid) begin
        reset = 1'b0;
        #1;
        chk("reset_valid", dout_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_idx", dout_idx, 0);
        dout_ready = 1'b0;
        return;
      end
      stalled = dout_valid && !dout_ready;
      h_dout  = dout;
      h_idx   = dout_idx;
      h_last  = dout_last;
      h_intt  = dout_intt;
      if (dout_valid && dout_ready) begin
        chk("dout", dout, rows[k / LANES][k % LANES]);
        chk("dout_idx", dout_idx, k);
        chk("dout_last", dout_last, (k == RSZ - 1));
        chk("dout_intt", dout_intt, exp_intt);
        if (b2b && k == RSZ - 1) begin
          done     = 1'b1;
          op_intt  = 1'b1;
          done_cyc = cyc;
        end
        k++;
      end
      tick();
      done = 1'b0;
    end
    if (b2b) begin
      chk("b2b_busy", busy, 1);
      chk("b2b_overrun", overrun, 0);
    end else begin
      chk("valid_after_last", dout_valid, 0);
      chk("busy_after_last", busy, 0);
    end
  endtask

  task automatic watch_idle(input int n);
    bit any = 1'b0;
    for (int i = 0; i < n; i++) begin
      dout_ready = 1'($urandom);
      tick();
      any |= dout_valid;
    end
    chk("no_spurious_output", any, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    lfsr  = 16'hACE1;
    reset = 1'b0;
    repeat (20) tick();
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_idx", dout_idx, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_intt", dout_intt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b1;
    repeat (3) tick();

    // Basic NTT frame, ramp data so dout equals its index.
    fill_rows(1'b0, '0);
    start_frame(1'b0);
    drive_rows(-1);
    drain(1'b0, 1'b0, -1, 1'b0);

    // Backpressure with random data.
    fill_rows(1'b1, '0);
    start_frame(1'b0);
    drive_rows(-1);
    drain(1'b1, 1'b0, -1, 1'b0);

    // Back-to-back: INTT frame accepted on the final handshake.
    fill_rows(1'b1, '0);
    start_frame(1'b0);
    drive_rows(-1);
    drain(1'b0, 1'b1, -1, 1'b0);
    fill_rows(1'b0, 64'h1000);
    drive_rows(-1);
    drain(1'b1, 1'b0, -1, 1'b1);
    chk("b2b_no_overrun", overrun, 0);

    // Stray done during capture.
    fill_rows(1'b1, '0);
    start_frame(1'b1);
    drive_rows(30);
    drain(1'b0, 1'b0, -1, 1'b1);
    watch_idle(150);
    chk("overrun_sticky", overrun, 1);

    // Reset mid-drain, then a clean frame.
    fill_rows(1'b1, '0);
    start_frame(1'b0);
    drive_rows(-1);
    drain(1'b1, 1'b0, 500, 1'b0);
    repeat (5) tick();
    chk("held_reset_busy", busy, 0);
    reset = 1'b1;
    watch_idle(100);
    chk("post_reset_overrun", overrun, 0);
    fill_rows(1'b1, '0);
    start_frame(1'b1);
    drive_rows(-1);
    drain(1'b0, 1'b0, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
